fixed_dwn_row_flatten_sequencer: RTL and testbench
==================================================

# fixed_dwn_row_flatten_sequencer

Row-serial front end for the DWN flatten stage. It accepts a 2-D binary feature map one row (IN_COLS bits) per valid/ready handshake, buffers the rows, and emits the complete IN_COLS*IN_ROWS flattened vector as one output beat. It sits between a row-streaming producer (e.g. a DWN LUT layer emitting one row per cycle) and the DWN layers that consume a flat input vector. It also checks frame framing through a last-row marker.

## Interface
- IN_COLS, 2, bits per row (>=1)
- IN_ROWS, 2, rows per frame (>=1)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- data_in_0  input  IN_COLS  one row of the feature map
- data_in_0_valid  input  1  row present
- data_in_0_ready  output  1  row accepted when valid&&ready
- data_in_0_last  input  1  producer marks final row of frame; sampled only on accepted beats
- data_out_0  output  IN_COLS*IN_ROWS  flattened frame; bit i*IN_COLS+j = row i, bit j
- data_out_0_valid  output  1  frame available
- data_out_0_ready  input  1  downstream accepts frame
- frame_err  output  1  one-cycle pulse on framing violation

## Operation
- State: FILL (collecting rows) or FULL (holding complete frame). Row counter row_cnt, width max(1,$clog2(IN_ROWS)).
- Buffer: IN_COLS*IN_ROWS register; accepted row at row_cnt written to bits [row_cnt*IN_COLS +: IN_COLS]; other slices untouched. data_out_0 drives the buffer directly.
- data_in_0_ready = (state==FILL) || (state==FULL && data_out_0_ready). Combinational path from data_out_0_ready to data_in_0_ready is intended.
- FILL, accept, row_cnt < IN_ROWS-1, last=0: write row, row_cnt++.
- FILL, accept, row_cnt == IN_ROWS-1: write row, row_cnt<=0, go FULL. If last=0, pulse frame_err; frame still emitted (count is authoritative).
- FILL, accept, row_cnt < IN_ROWS-1, last=1 (early last): row discarded, partial frame dropped, row_cnt<=0, stay FILL, pulse frame_err.
- FULL, output handshake, no input accept: go FILL.
- FULL, output handshake and input accept same cycle: row written as row 0 of the next frame (same rules as FILL with row_cnt=0), row_cnt<=1 or go FULL again if IN_ROWS==1.
- FULL, no output handshake: data_out_0 and data_out_0_valid held stable; no input accepted.
- IN_ROWS==1: every accepted row is a complete frame; last must be 1 on every beat or frame_err pulses.
- frame_err is registered, high exactly one cycle per violating beat; it does not affect data_out_0_valid.

## Timing
- Reset values: data_out_0_valid=0, data_out_0=0, frame_err=0, data_in_0_ready=1, state=FILL, row_cnt=0.
- Reset asserted mid-frame or while FULL: partial/held frame discarded, no output beat emitted.
- Latency: final row accepted at edge N -> data_out_0_valid=1 after edge N, data_out_0 reflects all rows.
- Throughput with data_out_0_ready=1 continuously: one frame per IN_ROWS cycles, no bubble.
- frame_err asserted the cycle after the violating accept.
- data_out_0 never changes while data_out_0_valid=1 and data_out_0_ready=0.

## Test plan
- IN_COLS=2, IN_ROWS=2: rows 2'b01 (last=0), 2'b10 (last=1), out_ready=1 -> one beat data_out_0=4'b1001, frame_err=0, valid high one cycle.
- Backpressure: same frame, out_ready=0 for 5 cycles -> data_out_0 holds 4'b1001, data_in_0_ready=0 throughout, releases one cycle after ready=1.
- Streaming: 8 consecutive rows with valid=1, out_ready=1, correct last -> 4 frames on 4 alternating cycles, data_in_0_ready never drops.
- Early last: row 2'b11 with last=1 at row 0 -> frame_err pulse, no output; following rows 2'b00/2'b01 -> data_out_0=4'b0100.
- Missing last: rows 2'b10, 2'b01 both last=0 -> frame_err pulse and data_out_0=4'b0110 emitted.
- Reset after one row accepted -> no output beat; next two rows 2'b11, 2'b00 -> data_out_0=4'b0011; IN_ROWS=1 config: each row emitted next cycle.

Source files
------------

// File: rtl/fixed_dwn_row_flatten_sequencer.sv
// Row-serial to flat-vector sequencer for the DWN flatten stage.
// Collects IN_ROWS rows of IN_COLS bits, emits the frame as one beat and flags last-row framing errors.
module fixed_dwn_row_flatten_sequencer #(
    parameter int IN_COLS = 2,
    parameter int IN_ROWS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [IN_COLS-1:0]         data_in_0,
    input  logic                       data_in_0_valid,
    output logic                       data_in_0_ready,
    input  logic                       data_in_0_last,
    output logic [IN_COLS*IN_ROWS-1:0] data_out_0,
    output logic                       data_out_0_valid,
    input  logic                       data_out_0_ready,
    output logic                       frame_err
);

    // state | meaning
    // FILL  | collecting rows into the buffer
    // FULL  | complete frame presented on data_out_0
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam int CW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(IN_ROWS - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [CW-1:0]              r_row_cnt;
    logic [CW-1:0]              w_row_cnt_nxt;
    logic [IN_COLS*IN_ROWS-1:0] r_buf;
    logic                       r_err;
    logic                       w_err_nxt;
    logic                       w_accept;
    logic                       w_wr;

    assign data_in_0_ready  = (r_state == FILL) || ((r_state == FULL) && data_out_0_ready);
    assign w_accept         = data_in_0_valid && data_in_0_ready;
    assign data_out_0       = r_buf;
    assign data_out_0_valid = (r_state == FULL);
    assign frame_err        = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= FILL;
            r_row_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_row_cnt <= w_row_cnt_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // row_cnt is always zero while FULL, so an accept during the output
    // handshake naturally lands in row 0 of the next frame.
    always_comb begin
        w_state_nxt   = r_state;
        w_row_cnt_nxt = r_row_cnt;
        w_err_nxt     = 1'b0;
        w_wr          = 1'b0;
        if ((r_state == FULL) && data_out_0_ready) begin
            w_state_nxt = FILL;
        end
        if (w_accept) begin
            if (r_row_cnt == LAST_ROW) begin
                w_wr          = 1'b1;
                w_row_cnt_nxt = '0;
                w_state_nxt   = FULL;
                w_err_nxt     = ~data_in_0_last;
            end else if (data_in_0_last) begin
                w_row_cnt_nxt = '0;
                w_err_nxt     = 1'b1;
            end else begin
                w_wr          = 1'b1;
                w_row_cnt_nxt = r_row_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf <= '0;
        end else if (w_wr) begin
            r_buf[r_row_cnt*IN_COLS +: IN_COLS] <= data_in_0;
        end
    end

endmodule

// File: tb/tb_fixed_dwn_row_flatten_sequencer.sv
// Self-checking bench: 2x2 instance against a queue-based frame model, plus a 2x1 instance.
module tb_fixed_dwn_row_flatten_sequencer;

    localparam int COLS = 2;
    localparam int ROWS = 2;

    typedef struct packed {
        logic       v;
        logic [1:0] d;
        logic       l;
        logic       r;
    } stim_t;

    logic            clk;
    logic            rst;
    logic [COLS-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic [3:0]      dout;
    logic            dout_valid;
    logic            out_ready;
    logic            ferr;

    logic [1:0]      s1_data;
    logic            s1_valid;
    logic            s1_ready;
    logic            s1_last;
    logic [1:0]      s1_dout;
    logic            s1_dout_valid;
    logic            s1_out_ready;
    logic            s1_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [COLS-1:0] m_rows[$];
    logic            m_valid;
    logic [3:0]      m_frame;
    logic            m_err;
    logic            m_rdy;
    logic            rdy_obs;

    fixed_dwn_row_flatten_sequencer #(.IN_COLS(COLS), .IN_ROWS(ROWS)) dut (
        .clk(clk), .rst(rst),
        .data_in_0(in_data), .data_in_0_valid(in_valid), .data_in_0_ready(in_ready),
        .data_in_0_last(in_last),
        .data_out_0(dout), .data_out_0_valid(dout_valid), .data_out_0_ready(out_ready),
        .frame_err(ferr)
    );

    fixed_dwn_row_flatten_sequencer #(.IN_COLS(2), .IN_ROWS(1)) dut1 (
        .clk(clk), .rst(rst),
        .data_in_0(s1_data), .data_in_0_valid(s1_valid), .data_in_0_ready(s1_ready),
        .data_in_0_last(s1_last),
        .data_out_0(s1_dout), .data_out_0_valid(s1_dout_valid), .data_out_0_ready(s1_out_ready),
        .frame_err(s1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_rows.delete();
        m_valid = 1'b0;
        m_frame = '0;
        m_err   = 1'b0;
        m_rdy   = 1'b1;
    endtask

    // Drives one cycle, advances the frame model across the edge, returns at posedge+1.
    task automatic step(input logic v, input logic [1:0] d, input logic l, input logic ordy);
        logic acc;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        #1;
        rdy_obs = in_ready;
        m_rdy   = !m_valid || ordy;
        acc     = v && m_rdy;
        if (m_valid && ordy) m_valid = 1'b0;
        m_err = 1'b0;
        if (acc) begin
            m_rows.push_back(d);
            if (m_rows.size() == ROWS) begin
                for (int i = 0; i < ROWS; i++) m_frame[i*COLS +: COLS] = m_rows[i];
                m_valid = 1'b1;
                m_err   = !l;
                m_rows.delete();
            end else if (l) begin
                m_rows.delete();
                m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
        n_checks++; if (dout !== 4'b0000) begin n_fail++; $display("FAIL reset_data got %b exp 0000", dout); end
        n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", ferr); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        n_checks++; if (s1_dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid1 got %b exp 0", s1_dout_valid); end
    endtask

    task automatic test_basic_backpressure();
        stim_t s[$];
        s.push_back({1'b1, 2'b01, 1'b0, 1'b1});
        s.push_back({1'b1, 2'b10, 1'b1, 1'b1});
        s.push_back({1'b0, 2'b00, 1'b0, 1'b1});
        s.push_back({1'b1, 2'b01, 1'b0, 1'b0});
        s.push_back({1'b1, 2'b10, 1'b1, 1'b0});
        for (int i = 0; i < 5; i++) s.push_back({1'b1, 2'b11, 1'b0, 1'b0});
        s.push_back({1'b1, 2'b11, 1'b0, 1'b1});
        s.push_back({1'b1, 2'b00, 1'b1, 1'b1});
        s.push_back({1'b0, 2'b00, 1'b0, 1'b1});
        foreach (s[k]) begin
            step(s[k].v, s[k].d, s[k].l, s[k].r);
            n_checks++; if (rdy_obs !== m_rdy) begin n_fail++; $display("FAIL basic_ready step %0d got %b exp %b", k, rdy_obs, m_rdy); end
            n_checks++; if (dout_valid !== m_valid) begin n_fail++; $display("FAIL basic_valid step %0d got %b exp %b", k, dout_valid, m_valid); end
            n_checks++; if (ferr !== m_err) begin n_fail++; $display("FAIL basic_err step %0d got %b exp %b", k, ferr, m_err); end
            if (m_valid) begin
                n_checks++; if (dout !== m_frame) begin n_fail++; $display("FAIL basic_data step %0d got %b exp %b", k, dout, m_frame); end
            end
            if (k == 1 || (k >= 4 && k <= 9)) begin
                n_checks++; if (dout !== 4'b1001) begin n_fail++; $display("FAIL basic_1001 step %0d got %b exp 1001", k, dout); end
            end
            if (k == 11) begin
                n_checks++; if (dout !== 4'b0011) begin n_fail++; $display("FAIL basic_0011 got %b exp 0011", dout); end
            end
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) step(1'b1, 2'($urandom), 1'(i % 2), 1'b1);
            else       step(1'b0, 2'b00, 1'b0, 1'b1);
            n_checks++; if (rdy_obs !== 1'b1) begin n_fail++; $display("FAIL stream_ready step %0d got %b exp 1", i, rdy_obs); end
            n_checks++; if (dout_valid !== m_valid) begin n_fail++; $display("FAIL stream_valid step %0d got %b exp %b", i, dout_valid, m_valid); end
            n_checks++; if (ferr !== m_err) begin n_fail++; $display("FAIL stream_err step %0d got %b exp %b", i, ferr, m_err); end
            if (m_valid) begin
                n_checks++; if (dout !== m_frame) begin n_fail++; $display("FAIL stream_data step %0d got %b exp %b", i, dout, m_frame); end
            end
        end
    endtask

    task automatic test_framing();
        stim_t s[$];
        s.push_back({1'b1, 2'b11, 1'b1, 1'b1});
        s.push_back({1'b1, 2'b00, 1'b0, 1'b1});
        s.push_back({1'b1, 2'b01, 1'b1, 1'b1});
        s.push_back({1'b1, 2'b10, 1'b0, 1'b1});
        s.push_back({1'b1, 2'b01, 1'b0, 1'b1});
        s.push_back({1'b0, 2'b00, 1'b0, 1'b1});
        foreach (s[k]) begin
            step(s[k].v, s[k].d, s[k].l, s[k].r);
            n_checks++; if (dout_valid !== m_valid) begin n_fail++; $display("FAIL framing_valid step %0d got %b exp %b", k, dout_valid, m_valid); end
            n_checks++; if (ferr !== m_err) begin n_fail++; $display("FAIL framing_err step %0d got %b exp %b", k, ferr, m_err); end
            if (m_valid) begin
                n_checks++; if (dout !== m_frame) begin n_fail++; $display("FAIL framing_data step %0d got %b exp %b", k, dout, m_frame); end
            end
        end
        n_checks++; if (m_frame !== 4'b0110) begin n_fail++; $display("FAIL framing_model got %b exp 0110", m_frame); end
    endtask

    task automatic test_reset_midframe();
        step(1'b1, 2'b01, 1'b0, 1'b1);
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b exp 0", dout_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: step(1'b1, 2'b11, 1'b0, 1'b1);
                1: step(1'b1, 2'b00, 1'b1, 1'b1);
                default: step(1'b0, 2'b00, 1'b0, 1'b1);
            endcase
            n_checks++; if (dout_valid !== m_valid) begin n_fail++; $display("FAIL rstmid_valid step %0d got %b exp %b", i, dout_valid, m_valid); end
            n_checks++; if (ferr !== m_err) begin n_fail++; $display("FAIL rstmid_err step %0d got %b exp %b", i, ferr, m_err); end
            if (i == 1) begin
                n_checks++; if (dout !== 4'b0011) begin n_fail++; $display("FAIL rstmid_data got %b exp 0011", dout); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0));
            n_checks++; if (rdy_obs !== m_rdy) begin n_fail++; $display("FAIL random_ready step %0d got %b exp %b", i, rdy_obs, m_rdy); end
            n_checks++; if (dout_valid !== m_valid) begin n_fail++; $display("FAIL random_valid step %0d got %b exp %b", i, dout_valid, m_valid); end
            n_checks++; if (ferr !== m_err) begin n_fail++; $display("FAIL random_err step %0d got %b exp %b", i, ferr, m_err); end
            if (m_valid) begin
                n_checks++; if (dout !== m_frame) begin n_fail++; $display("FAIL random_data step %0d got %b exp %b", i, dout, m_frame); end
            end
        end
    endtask

    task automatic test_single_row();
        logic       p_valid;
        logic [1:0] p_frame;
        logic       p_err;
        logic       p_rdy;
        logic       v, l, ordy;
        logic [1:0] d;
        p_valid = 1'b0;
        p_frame = '0;
        for (int i = 0; i < 40; i++) begin
            v = 1'($urandom_range(0, 3) != 0);
            d = 2'($urandom);
            l = 1'($urandom_range(0, 3) != 0);
            ordy = (i < 8) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            s1_valid = v; s1_data = d; s1_last = l; s1_out_ready = ordy;
            #1;
            p_rdy = !p_valid || ordy;
            n_checks++; if (s1_ready !== p_rdy) begin n_fail++; $display("FAIL single_ready step %0d got %b exp %b", i, s1_ready, p_rdy); end
            if (p_valid && ordy) p_valid = 1'b0;
            p_err = 1'b0;
            if (v && p_rdy) begin
                p_valid = 1'b1;
                p_frame = d;
                p_err   = !l;
            end
            @(posedge clk);
            #1;
            n_checks++; if (s1_dout_valid !== p_valid) begin n_fail++; $display("FAIL single_valid step %0d got %b exp %b", i, s1_dout_valid, p_valid); end
            n_checks++; if (s1_err !== p_err) begin n_fail++; $display("FAIL single_err step %0d got %b exp %b", i, s1_err, p_err); end
            if (p_valid) begin
                n_checks++; if (s1_dout !== p_frame) begin n_fail++; $display("FAIL single_data step %0d got %b exp %b", i, s1_dout, p_frame); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0; s1_out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_basic_backpressure();
        test_stream();
        test_framing();
        test_reset_midframe();
        test_random();
        test_single_row();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
